spike_pattern_decoder: RTL and testbench

Reads the N-bit spike-frame vector produced by the time-multiplexed Hopfield network and converts it back into a P-bit recalled pattern. It performs rate decoding: per-neuron spike counts are accumulated over a fixed window of frames and then thresholded. The decoded pattern is presented on a valid/ready handshake to downstream logic, such as the output pins or a pattern comparator. It is the reader for the network's spike output, complementing the pattern_input encoder side.

---
 rtl/spike_pattern_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_spike_pattern_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/spike_pattern_decoder.sv
// spike_pattern_decoder
// Rate decoder for the Hopfield network spike output. Each neuron's spikes are
// counted over a window of WINDOW frames. Every count is then compared against
// THRESH to produce the recalled pattern (neurons 0..P-1) and a count of active
// neurons (all N). The result is offered on a valid/ready handshake.
//
// Optional build macro:
//   DECODER_HYST_EN - a pattern bit that was 1 in the previous decision stays 1
//                     while its count is still at or above THRESH_LO. This
//                     suppresses flicker on marginal recall. active_count
//                     always uses THRESH.
module spike_pattern_decoder #(
  parameter int N         = 7,
  parameter int P         = 4,
  parameter int WINDOW    = 16,
  parameter int CNT_W     = 5,
  parameter int THRESH    = 4,
  parameter int THRESH_LO = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] spikes_in,
  input  logic         frame_valid,
  output logic [P-1:0] pattern_out,
  output logic [2:0]   active_count,
  output logic         pattern_valid,
  input  logic         pattern_ready,
  output logic         overrun
);

  // Frame counter is wide enough to hold WINDOW itself.
  localparam int FC_W = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THR_HI  = CNT_W'(THRESH);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(WINDOW - 1);
`ifdef DECODER_HYST_EN
  localparam logic [CNT_W-1:0] THR_LO  = CNT_W'(THRESH_LO);
`endif

  // Reject parameter sets the decoder cannot honour.
  generate
    if ((WINDOW < 2) || (WINDOW > 255)) begin : g_bad_window
      $error("spike_pattern_decoder: WINDOW must be in 2..255");
    end
    if (P > N) begin : g_bad_p
      $error("spike_pattern_decoder: P must not exceed N");
    end
    if (N > 7) begin : g_bad_n
      $error("spike_pattern_decoder: active_count is 3 bits, N must be <= 7");
    end
    if ((THRESH_LO > THRESH) || (THRESH > ((1 << CNT_W) - 1))) begin : g_bad_thresh
      $error("spike_pattern_decoder: need THRESH_LO <= THRESH <= 2^CNT_W-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DECIDE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r     [N];
  logic [CNT_W-1:0] cnt_inc_s [N];
  logic [FC_W-1:0]  frame_cnt_r;
  logic [N-1:0]     hi_s;
  logic [P-1:0]     pat_dec_s;
  logic [2:0]       active_s;

  // Saturating increment of one spike counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             s);
    if (s && (c != CNT_MAX)) begin
      return c + CNT_W'(1);
    end else begin
      return c;
    end
  endfunction

  // Number of set bits in the per-neuron threshold vector.
  function automatic logic [2:0] popcount(input logic [N-1:0] v);
    logic [2:0] acc;
    acc = 3'd0;
    for (int i = 0; i < N; i++) begin
      acc = acc + {2'b00, v[i]};
    end
    return acc;
  endfunction

  // Next counter values and threshold decisions from the current counts.
  always_comb begin
    pat_dec_s = {P{1'b0}};
    for (int i = 0; i < N; i++) begin
      cnt_inc_s[i] = sat_inc(cnt_r[i], spikes_in[i]);
      hi_s[i]      = (cnt_r[i] >= THR_HI);
    end
    for (int i = 0; i < P; i++) begin
`ifdef DECODER_HYST_EN
      pat_dec_s[i] = hi_s[i] | (pattern_out[i] & (cnt_r[i] >= THR_LO));
`else
      pat_dec_s[i] = hi_s[i];
`endif
    end
    active_s = popcount(hi_s);
  end

  // Control FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      frame_cnt_r   <= {FC_W{1'b0}};
      for (int i = 0; i < N; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
      pattern_out   <= {P{1'b0}};
      active_count  <= 3'd0;
      pattern_valid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Counters stay cleared; frames are ignored while idle.
          frame_cnt_r <= {FC_W{1'b0}};
          for (int i = 0; i < N; i++) begin
            cnt_r[i] <= {CNT_W{1'b0}};
          end
          if (enable) begin
            state_r <= ST_ACCUM;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_ACCUM: begin
          if (!enable) begin
            // Abort wins over a coincident frame: that frame is not counted.
            state_r     <= ST_IDLE;
            frame_cnt_r <= {FC_W{1'b0}};
            for (int i = 0; i < N; i++) begin
              cnt_r[i] <= {CNT_W{1'b0}};
            end
          end else if (frame_valid) begin
            for (int i = 0; i < N; i++) begin
              cnt_r[i] <= cnt_inc_s[i];
            end
            frame_cnt_r <= frame_cnt_r + FC_W'(1);
            if (frame_cnt_r == FC_LAST) begin
              state_r <= ST_DECIDE;
            end else begin
              state_r <= ST_ACCUM;
            end
          end else begin
            state_r <= ST_ACCUM;
          end
        end

        ST_DECIDE: begin
          pattern_out   <= pat_dec_s;
          active_count  <= active_s;
          pattern_valid <= 1'b1;
          frame_cnt_r   <= {FC_W{1'b0}};
          for (int i = 0; i < N; i++) begin
            cnt_r[i] <= {CNT_W{1'b0}};
          end
          if (frame_valid) begin
            overrun <= 1'b1;
          end else begin
            overrun <= overrun;
          end
          state_r <= ST_HOLD;
        end

        ST_HOLD: begin
          // Result is frozen until accepted; enable only matters afterwards.
          if (frame_valid) begin
            overrun <= 1'b1;
          end else begin
            overrun <= overrun;
          end
          if (pattern_ready) begin
            pattern_valid <= 1'b0;
            if (enable) begin
              state_r <= ST_ACCUM;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_HOLD;
          end
        end

        default: begin
          state_r       <= ST_IDLE;
          frame_cnt_r   <= {FC_W{1'b0}};
          for (int i = 0; i < N; i++) begin
            cnt_r[i] <= {CNT_W{1'b0}};
          end
          pattern_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_pattern_decoder.sv
// Directed bench for spike_pattern_decoder with hand-computed expectations.
// Frames are strobed every 7 clocks, as the network produces them.
module tb_spike_pattern_decoder;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [6:0] spikes_in;
  logic       frame_valid;
  logic [3:0] pattern_out;
  logic [2:0] active_count;
  logic       pattern_valid;
  logic       pattern_ready;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  spike_pattern_decoder dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .spikes_in     (spikes_in),
    .frame_valid   (frame_valid),
    .pattern_out   (pattern_out),
    .active_count  (active_count),
    .pattern_valid (pattern_valid),
    .pattern_ready (pattern_ready),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame strobe, then gap idle clocks.
  task automatic send_frame(input logic [6:0] s, input int gap);
    spikes_in   = s;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    spikes_in   = 7'b0;
    repeat (gap) tick();
  endtask

  // Called right after the last window frame was accepted.
  task automatic finish_window(input string tag, input logic [3:0] exp_pat, input logic [2:0] exp_act);
    check_eq({tag, "_decide_valid"}, {31'b0, pattern_valid}, 32'd0);
    tick();
    check_eq({tag, "_valid"}, {31'b0, pattern_valid}, 32'd1);
    check_eq({tag, "_pattern"}, {28'b0, pattern_out}, {28'b0, exp_pat});
    check_eq({tag, "_active"}, {29'b0, active_count}, {29'b0, exp_act});
  endtask

  logic [6:0] v;
  logic [3:0] hyst_exp;

  initial begin
    reset         = 1'b1;
    enable        = 1'b0;
    spikes_in     = 7'b0;
    frame_valid   = 1'b0;
    pattern_ready = 1'b1;
    tick();
    tick();
    check_eq("rst_valid",   {31'b0, pattern_valid}, 32'd0);
    check_eq("rst_pattern", {28'b0, pattern_out},   32'd0);
    check_eq("rst_active",  {29'b0, active_count},  32'd0);
    check_eq("rst_overrun", {31'b0, overrun},       32'd0);

    // Test 1: neurons 0 and 2 spike every frame.
    reset  = 1'b0;
    enable = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) send_frame(7'b0000101, (k == 15) ? 0 : 6);
    finish_window("t1", 4'b0101, 3'd2);
    check_eq("t1_overrun", {31'b0, overrun}, 32'd0);
    tick();
    check_eq("t1_one_cycle_valid", {31'b0, pattern_valid}, 32'd0);

    // Test 2: neuron0 x4, neuron1 x3, neurons 4-6 x16.
    for (int k = 0; k < 16; k++) begin
      v = 7'b1110000;
      if (k < 4) v[0] = 1'b1;
      if (k < 3) v[1] = 1'b1;
      send_frame(v, (k == 15) ? 0 : 6);
    end
    finish_window("t2", 4'b0001, 3'd4);
    tick();
    check_eq("t2_handshake", {31'b0, pattern_valid}, 32'd0);

    // Test 3: hold ready low while strobes keep coming.
    pattern_ready = 1'b0;
    for (int k = 0; k < 16; k++) send_frame(7'b0001000, (k == 15) ? 0 : 6);
    finish_window("t3", 4'b1000, 3'd1);
    check_eq("t3_overrun_pre", {31'b0, overrun}, 32'd0);
    for (int j = 0; j < 20; j++) begin
      frame_valid = ((j % 7) == 4);
      spikes_in   = frame_valid ? 7'b1111111 : 7'b0;
      tick();
      if (j == 3) check_eq("t3_overrun_before_drop", {31'b0, overrun}, 32'd0);
      if (j == 4) check_eq("t3_overrun_after_drop", {31'b0, overrun}, 32'd1);
    end
    frame_valid = 1'b0;
    spikes_in   = 7'b0;
    check_eq("t3_hold_valid",   {31'b0, pattern_valid}, 32'd1);
    check_eq("t3_hold_pattern", {28'b0, pattern_out},   32'h8);
    check_eq("t3_hold_active",  {29'b0, active_count},  32'd1);
    pattern_ready = 1'b1;
    tick();
    check_eq("t3_release", {31'b0, pattern_valid}, 32'd0);
    // Neuron0 spikes once here; dropped HOLD frames must not add to it.
    for (int k = 0; k < 16; k++) send_frame((k == 0) ? 7'b0000011 : 7'b0000010, (k == 15) ? 0 : 6);
    finish_window("t3_post", 4'b0010, 3'd1);
    tick();

    // Test 4: abort after 8 frames, then a clean all-ones window.
    for (int k = 0; k < 8; k++) send_frame(7'b1111111, 6);
    enable = 1'b0;
    tick();
    repeat (3) tick();
    check_eq("t4_abort_valid", {31'b0, pattern_valid}, 32'd0);
    enable = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) send_frame(7'b1111111, (k == 15) ? 0 : 6);
    finish_window("t4", 4'hF, 3'd7);
    tick();

    // Test 6: hysteresis on neuron2 (5 spikes, then 3 spikes).
    for (int k = 0; k < 16; k++) send_frame((k < 5) ? 7'b0000100 : 7'b0, (k == 15) ? 0 : 6);
    finish_window("hyA", 4'b0100, 3'd1);
    tick();
    pattern_ready = 1'b0;
`ifdef DECODER_HYST_EN
    hyst_exp = 4'b0100;
`else
    hyst_exp = 4'b0000;
`endif
    for (int k = 0; k < 16; k++) send_frame((k < 3) ? 7'b0000100 : 7'b0, (k == 15) ? 0 : 6);
    finish_window("hyB", hyst_exp, 3'd0);

    // Test 5: reset while holding a result with overrun set.
    tick();
    check_eq("t5_hold_valid", {31'b0, pattern_valid}, 32'd1);
    send_frame(7'b1111111, 0);
    check_eq("t5_overrun_set", {31'b0, overrun}, 32'd1);
    reset = 1'b1;
    tick();
    check_eq("t5_rst_valid",   {31'b0, pattern_valid}, 32'd0);
    check_eq("t5_rst_pattern", {28'b0, pattern_out},   32'd0);
    check_eq("t5_rst_active",  {29'b0, active_count},  32'd0);
    check_eq("t5_rst_overrun", {31'b0, overrun},       32'd0);
    reset  = 1'b0;
    enable = 1'b0;
    tick();
    send_frame(7'b1111111, 2);
    check_eq("t5_idle_no_overrun", {31'b0, overrun},       32'd0);
    check_eq("t5_idle_no_valid",   {31'b0, pattern_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
